// File: rtl/video_pkg.sv
// Shared pixel types, pattern identifiers and colour constants for the
// test pattern source.
package video_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [2:0] {
    PAT_BARS  = 3'd0,
    PAT_CHECK = 3'd1,
    PAT_GRAD  = 3'd2,
    PAT_BOX   = 3'd3,
    PAT_GREY  = 3'd4
  } pattern_e;

  localparam int NUM_PATTERNS = 5;

  localparam rgb_t COL_WHITE   = 24'hFF_FF_FF;
  localparam rgb_t COL_YELLOW  = 24'hFF_FF_00;
  localparam rgb_t COL_CYAN    = 24'h00_FF_FF;
  localparam rgb_t COL_GREEN   = 24'h00_FF_00;
  localparam rgb_t COL_MAGENTA = 24'hFF_00_FF;
  localparam rgb_t COL_RED     = 24'hFF_00_00;
  localparam rgb_t COL_BLUE    = 24'h00_00_FF;
  localparam rgb_t COL_GREY    = 24'h80_80_80;
  localparam rgb_t COL_BLACK   = 24'h00_00_00;

  function automatic rgb_t bar_colour(input logic [2:0] idx);
    rgb_t c;
    case (idx)
      3'd0:    c = COL_WHITE;
      3'd1:    c = COL_YELLOW;
      3'd2:    c = COL_CYAN;
      3'd3:    c = COL_GREEN;
      3'd4:    c = COL_MAGENTA;
      3'd5:    c = COL_RED;
      3'd6:    c = COL_BLUE;
      default: c = COL_BLACK;
    endcase
    return c;
  endfunction

  function automatic pattern_e next_pattern(input pattern_e p);
    return (p == pattern_e'(NUM_PATTERNS - 1)) ? PAT_BARS : pattern_e'(3'(p) + 3'd1);
  endfunction

endpackage

// File: rtl/video_box_mover.sv
// Bouncing box position, one step per frame. Outputs the position that
// applies to the current pixel (already stepped on the frame_start cycle).
module video_box_mover #(
  parameter int HRES     = 640,
  parameter int VRES     = 480,
  parameter int COORDSPC = 16,
  parameter int BOX      = 32
) (
  input  logic                       clk_pix,
  input  logic                       rst_n,
  input  logic                       frame_start,
  output logic signed [COORDSPC-1:0] box_x,
  output logic signed [COORDSPC-1:0] box_y
);

  localparam logic signed [COORDSPC-1:0] ONE = COORDSPC'(1);

  logic [1:0][COORDSPC-1:0] pos_next;

  for (genvar gi = 0; gi < 2; gi++) begin : g_axis
    localparam logic signed [COORDSPC-1:0] LIMIT =
      COORDSPC'((gi == 0) ? (HRES - BOX) : (VRES - BOX));

    logic signed [COORDSPC-1:0] pos_q, pos_d;
    logic                       down_q, down_d;

    // Direction flips at an edge and the same frame already steps back inward.
    always_comb begin
      down_d = down_q;
      pos_d  = pos_q;
      if (frame_start) begin
        if (!down_q && (pos_q == LIMIT)) begin
          down_d = 1'b1;
        end else if (down_q && (pos_q == '0)) begin
          down_d = 1'b0;
        end
        pos_d = down_d ? (pos_q - ONE) : (pos_q + ONE);
      end
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
      if (!rst_n) begin
        pos_q  <= '0;
        down_q <= 1'b0;
      end else begin
        pos_q  <= pos_d;
        down_q <= down_d;
      end
    end

    assign pos_next[gi] = pos_d;
  end

  assign box_x = pos_next[0];
  assign box_y = pos_next[1];

endmodule

// File: rtl/video_test_pattern.sv
// Pixel-rate test pattern source: five patterns switched only at frame
// boundaries, two-stage colour pipeline with matching sync/enable delay.
module video_test_pattern
  import video_pkg::*;
#(
  parameter int HRES         = 640,
  parameter int VRES         = 480,
  parameter int COORDSPC     = 16,
  parameter int BOX          = 32,
  parameter int CHECK_SHIFT  = 5,
  parameter int CYCLE_FRAMES = 120
) (
  input  logic                       clk_pix,
  input  logic                       rst_n,
  input  logic                       video_enable,
  input  logic                       hsync,
  input  logic                       vsync,
  input  logic                       frame_start,
  input  logic signed [COORDSPC-1:0] sx,
  input  logic signed [COORDSPC-1:0] sy,
  input  logic                       auto_cycle,
  input  logic                       next_req,
  output logic [7:0]                 red,
  output logic [7:0]                 green,
  output logic [7:0]                 blue,
  output logic                       de_o,
  output logic                       hsync_o,
  output logic                       vsync_o,
  output logic [2:0]                 pattern_id
);

  localparam int CNT_W = (CYCLE_FRAMES > 1) ? $clog2(CYCLE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLE_FRAMES - 1);
  localparam logic signed [COORDSPC-1:0] H_END = COORDSPC'(HRES);
  localparam logic signed [COORDSPC-1:0] V_END = COORDSPC'(VRES);
  localparam logic signed [COORDSPC-1:0] BOX_W = COORDSPC'(BOX);

  pattern_e         pattern_q, pattern_d;
  logic             pending_q, pending_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             auto_adv;

  logic signed [COORDSPC-1:0] box_x, box_y;
  logic [7:1] bar_ge;
  logic [2:0] bar_idx;
  logic       in_active, in_box;

  rgb_t       s1_colour_q, s1_colour_d, rgb_q, rgb_d;
  logic       s1_active_q, s1_active_d;
  logic [2:0] s1_sync_q, s1_sync_d, s2_sync_q, s2_sync_d;  // {de, hsync, vsync}

  video_box_mover #(
    .HRES(HRES), .VRES(VRES), .COORDSPC(COORDSPC), .BOX(BOX)
  ) u_box_mover (
    .clk_pix(clk_pix),
    .rst_n(rst_n),
    .frame_start(frame_start),
    .box_x(box_x),
    .box_y(box_y)
  );

  for (genvar gi = 1; gi < 8; gi++) begin : g_bar_edge
    localparam logic signed [COORDSPC-1:0] EDGE = COORDSPC'(gi * HRES / 8);
    assign bar_ge[gi] = (sx >= EDGE);
  end

  // Pending and auto-advance on the same frame_start collapse to one step.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    auto_adv    = 1'b0;
    if (!auto_cycle) begin
      frame_cnt_d = '0;
    end else if (frame_start) begin
      if (frame_cnt_q == CNT_LAST) begin
        frame_cnt_d = '0;
        auto_adv    = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
      end
    end
    pending_d = frame_start ? next_req : (pending_q | next_req);
    pattern_d = (frame_start && (pending_q || auto_adv)) ? next_pattern(pattern_q) : pattern_q;
  end

  // Decode uses pattern_d so the first pixel of a frame already sees the new pattern.
  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (bar_ge[k]) bar_idx = 3'(k);
    end
    in_active = video_enable && !sx[COORDSPC-1] && !sy[COORDSPC-1] &&
                (sx < H_END) && (sy < V_END);
    in_box    = (sx >= box_x) && (sx < box_x + BOX_W) &&
                (sy >= box_y) && (sy < box_y + BOX_W);
    case (pattern_d)
      PAT_BARS:  s1_colour_d = bar_colour(bar_idx);
      PAT_CHECK: s1_colour_d = (sx[CHECK_SHIFT] ^ sy[CHECK_SHIFT]) ? COL_WHITE : COL_BLACK;
      PAT_GRAD:  s1_colour_d = {sx[9:2], sy[9:2], 8'h80};
      PAT_BOX:   s1_colour_d = in_box ? COL_WHITE : COL_BLUE;
      PAT_GREY:  s1_colour_d = COL_GREY;
      default:   s1_colour_d = COL_BLACK;
    endcase
    s1_active_d = in_active;
    s1_sync_d   = {video_enable, hsync, vsync};
    rgb_d       = s1_active_q ? s1_colour_q : COL_BLACK;
    s2_sync_d   = s1_sync_q;
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      pattern_q   <= PAT_BARS;
      pending_q   <= 1'b0;
      frame_cnt_q <= '0;
      s1_colour_q <= COL_BLACK;
      s1_active_q <= 1'b0;
      s1_sync_q   <= '0;
      rgb_q       <= COL_BLACK;
      s2_sync_q   <= '0;
    end else begin
      pattern_q   <= pattern_d;
      pending_q   <= pending_d;
      frame_cnt_q <= frame_cnt_d;
      s1_colour_q <= s1_colour_d;
      s1_active_q <= s1_active_d;
      s1_sync_q   <= s1_sync_d;
      rgb_q       <= rgb_d;
      s2_sync_q   <= s2_sync_d;
    end
  end

  assign red        = rgb_q.r;
  assign green      = rgb_q.g;
  assign blue       = rgb_q.b;
  assign de_o       = s2_sync_q[2];
  assign hsync_o    = s2_sync_q[1];
  assign vsync_o    = s2_sync_q[0];
  assign pattern_id = pattern_q;

endmodule

// File: tb/tb_video_test_pattern.sv
// Self-checking bench for video_test_pattern: randomized pixels compared
// against an arithmetic reference of the pattern rules.
module tb_video_test_pattern;

  localparam int HRES = 640;
  localparam int VRES = 480;
  localparam int BOX  = 32;
  localparam int CF   = 4;

  logic clk_pix = 1'b0;
  logic rst_n = 1'b0;
  logic video_enable = 1'b0, hsync = 1'b0, vsync = 1'b0, frame_start = 1'b0;
  logic auto_cycle = 1'b0, next_req = 1'b0;
  logic signed [15:0] sx = '0, sy = '0;
  logic [7:0] red, green, blue;
  logic de_o, hsync_o, vsync_o;
  logic [2:0] pattern_id;

  int n_tests = 0;
  int n_fail  = 0;
  int n_fs    = 0;   // frame_starts seen since the last reset
  int exp_pat = 0;

  always #5 clk_pix = ~clk_pix;

  video_test_pattern #(
    .HRES(HRES), .VRES(VRES), .COORDSPC(16), .BOX(BOX), .CHECK_SHIFT(5), .CYCLE_FRAMES(CF)
  ) dut (
    .clk_pix(clk_pix), .rst_n(rst_n), .video_enable(video_enable), .hsync(hsync),
    .vsync(vsync), .frame_start(frame_start), .sx(sx), .sy(sy), .auto_cycle(auto_cycle),
    .next_req(next_req), .red(red), .green(green), .blue(blue), .de_o(de_o),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .pattern_id(pattern_id)
  );

  // Box bounces like a triangle wave over 0..lim with period 2*lim frames.
  function automatic int tri_pos(int n, int lim);
    int p;
    p = n % (2 * lim);
    return (p <= lim) ? p : (2 * lim - p);
  endfunction

  function automatic logic [23:0] ref_colour(int pat, int x, int y, bit en, int nfs);
    int bx, by;
    bx = tri_pos(nfs, HRES - BOX);
    by = tri_pos(nfs, VRES - BOX);
    if (!en || x < 0 || x >= HRES || y < 0 || y >= VRES) return 24'h000000;
    case (pat)
      0: case (x * 8 / HRES)
           0: return 24'hFFFFFF;
           1: return 24'hFFFF00;
           2: return 24'h00FFFF;
           3: return 24'h00FF00;
           4: return 24'hFF00FF;
           5: return 24'hFF0000;
           6: return 24'h0000FF;
           default: return 24'h000000;
         endcase
      1: return ((((x / 32) + (y / 32)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
      2: return {8'(x / 4), 8'(y / 4), 8'h80};
      3: return (x >= bx && x < bx + BOX && y >= by && y < by + BOX) ? 24'hFFFFFF : 24'h0000FF;
      default: return 24'h808080;
    endcase
  endfunction

  task automatic probe(input int x, input int y, input bit en, output logic [23:0] got);
    @(negedge clk_pix);
    sx = 16'(x); sy = 16'(y); video_enable = en; hsync = 1'b0; vsync = 1'b0;
    @(negedge clk_pix);
    video_enable = 1'b0; sx = '0; sy = '0;
    @(negedge clk_pix);
    got = {red, green, blue};
  endtask

  task automatic frame(input bit nr, output logic [23:0] got);
    @(negedge clk_pix);
    frame_start = 1'b1; next_req = nr; sx = '0; sy = '0; video_enable = 1'b1;
    n_fs++;
    @(negedge clk_pix);
    frame_start = 1'b0; next_req = 1'b0; video_enable = 1'b0;
    @(negedge clk_pix);
    got = {red, green, blue};
  endtask

  task automatic pulse_req();
    @(negedge clk_pix); next_req = 1'b1;
    @(negedge clk_pix); next_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_pix);
    rst_n = 1'b0; video_enable = 1'b0; hsync = 1'b0; vsync = 1'b0;
    frame_start = 1'b0; next_req = 1'b0; auto_cycle = 1'b0;
    @(negedge clk_pix);
    @(negedge clk_pix);
    rst_n = 1'b1; n_fs = 0; exp_pat = 0;
  endtask

  task automatic test_reset();
    video_enable = 1'b1; hsync = 1'b1; vsync = 1'b1;
    repeat (3) @(negedge clk_pix);
    n_tests++; if ({red, green, blue, de_o, hsync_o, vsync_o, pattern_id} !== 30'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", {red, green, blue, de_o, hsync_o, vsync_o, pattern_id}); end
    rst_n = 1'b1; n_fs = 0; exp_pat = 0;
    @(negedge clk_pix);
    n_tests++; if (pattern_id !== 3'd0) begin
      n_fail++; $display("FAIL reset_pattern: got %0d expected 0", pattern_id); end
    @(negedge clk_pix);
    n_tests++; if ({de_o, hsync_o, vsync_o, red, green, blue} !== {3'b111, 24'hFFFFFF}) begin
      n_fail++; $display("FAIL reset_resume: got %h expected %h", {de_o, hsync_o, vsync_o, red, green, blue}, {3'b111, 24'hFFFFFF}); end
    video_enable = 1'b0; hsync = 1'b0; vsync = 1'b0;
    $display("[TB] test_reset done");
  endtask

  task automatic test_color_bars();
    logic [23:0] got, want;
    int x, y;
    probe(0, 10, 1'b1, got);
    n_tests++; if (got !== 24'hFFFFFF) begin n_fail++; $display("FAIL bars_x0: got %h expected FFFFFF", got); end
    probe(79, 10, 1'b1, got);
    n_tests++; if (got !== 24'hFFFFFF) begin n_fail++; $display("FAIL bars_x79: got %h expected FFFFFF", got); end
    probe(80, 10, 1'b1, got);
    n_tests++; if (got !== 24'hFFFF00) begin n_fail++; $display("FAIL bars_x80: got %h expected FFFF00", got); end
    probe(639, 479, 1'b1, got);
    n_tests++; if (got !== 24'h000000) begin n_fail++; $display("FAIL bars_x639: got %h expected 000000", got); end
    for (int i = 0; i < 8; i++) begin
      x = $urandom_range(0, HRES - 1); y = $urandom_range(0, VRES - 1);
      probe(x, y, 1'b1, got); want = ref_colour(0, x, y, 1'b1, n_fs);
      n_tests++; if (got !== want) begin n_fail++; $display("FAIL bars_rand x=%0d: got %h expected %h", x, got, want); end
    end
    $display("[TB] test_color_bars done");
  endtask

  task automatic test_next_req();
    logic [23:0] got, want;
    int x, y;
    pulse_req();
    repeat (4) @(negedge clk_pix);
    n_tests++; if (pattern_id !== 3'd0) begin n_fail++; $display("FAIL req_hold: got %0d expected 0", pattern_id); end
    frame(1'b0, got); exp_pat = 1;
    n_tests++; if (pattern_id !== 3'd1) begin n_fail++; $display("FAIL req_advance: got %0d expected 1", pattern_id); end
    n_tests++; if (got !== 24'h000000) begin n_fail++; $display("FAIL req_first_pixel: got %h expected 000000", got); end
    probe(32, 0, 1'b1, got);
    n_tests++; if (got !== 24'hFFFFFF) begin n_fail++; $display("FAIL check_32_0: got %h expected FFFFFF", got); end
    probe(0, 0, 1'b1, got);
    n_tests++; if (got !== 24'h000000) begin n_fail++; $display("FAIL check_0_0: got %h expected 000000", got); end
    for (int i = 0; i < 4; i++) begin
      x = $urandom_range(0, HRES - 1); y = $urandom_range(0, VRES - 1);
      probe(x, y, 1'b1, got); want = ref_colour(1, x, y, 1'b1, n_fs);
      n_tests++; if (got !== want) begin n_fail++; $display("FAIL check_rand (%0d,%0d): got %h expected %h", x, y, got, want); end
    end
    frame(1'b1, got);
    n_tests++; if (pattern_id !== 3'd1) begin n_fail++; $display("FAIL req_on_fs_same: got %0d expected 1", pattern_id); end
    frame(1'b0, got); exp_pat = 2;
    n_tests++; if (pattern_id !== 3'd2) begin n_fail++; $display("FAIL req_on_fs_next: got %0d expected 2", pattern_id); end
    $display("[TB] test_next_req done");
  endtask

  task automatic test_gradient();
    logic [23:0] got, want;
    int x, y;
    probe(400, 300, 1'b1, got);
    n_tests++; if (got !== 24'h644B80) begin n_fail++; $display("FAIL grad_400_300: got %h expected 644B80", got); end
    probe(400, 300, 1'b0, got);
    n_tests++; if (got !== 24'h000000) begin n_fail++; $display("FAIL grad_de0: got %h expected 000000", got); end
    probe(-5, 300, 1'b1, got);
    n_tests++; if (got !== 24'h000000) begin n_fail++; $display("FAIL grad_xneg: got %h expected 000000", got); end
    probe(640, 300, 1'b1, got);
    n_tests++; if (got !== 24'h000000) begin n_fail++; $display("FAIL grad_x640: got %h expected 000000", got); end
    probe(100, 480, 1'b1, got);
    n_tests++; if (got !== 24'h000000) begin n_fail++; $display("FAIL grad_y480: got %h expected 000000", got); end
    for (int i = 0; i < 4; i++) begin
      x = $urandom_range(0, HRES - 1); y = $urandom_range(0, VRES - 1);
      probe(x, y, 1'b1, got); want = ref_colour(2, x, y, 1'b1, n_fs);
      n_tests++; if (got !== want) begin n_fail++; $display("FAIL grad_rand (%0d,%0d): got %h expected %h", x, y, got, want); end
    end
    $display("[TB] test_gradient done");
  endtask

  task automatic test_auto_cycle();
    logic [23:0] got, want;
    bit pend;
    int x, y;
    pend = 1'b0;
    @(negedge clk_pix); auto_cycle = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      if (k == 8) begin pulse_req(); pend = 1'b1; end
      frame(k == 13, got);
      if ((k % CF == 0) || pend) exp_pat = (exp_pat + 1) % 5;
      pend = (k == 13);
      n_tests++; if (pattern_id !== 3'(exp_pat)) begin
        n_fail++; $display("FAIL auto_pattern frame %0d: got %0d expected %0d", k, pattern_id, exp_pat); end
      want = ref_colour(exp_pat, 0, 0, 1'b1, n_fs);
      n_tests++; if (got !== want) begin
        n_fail++; $display("FAIL auto_first_pixel frame %0d: got %h expected %h", k, got, want); end
      x = $urandom_range(0, HRES - 1); y = $urandom_range(0, VRES - 1);
      probe(x, y, 1'b1, got); want = ref_colour(exp_pat, x, y, 1'b1, n_fs);
      n_tests++; if (got !== want) begin
        n_fail++; $display("FAIL auto_pixel frame %0d (%0d,%0d): got %h expected %h", k, x, y, got, want); end
    end
    @(negedge clk_pix); auto_cycle = 1'b0;
    $display("[TB] test_auto_cycle done");
  endtask

  task automatic test_box();
    logic [23:0] got, want;
    int bx, by, px[4], py[4];
    do_reset();
    repeat (3) begin pulse_req(); frame(1'b0, got); end
    exp_pat = 3;
    n_tests++; if (pattern_id !== 3'd3) begin n_fail++; $display("FAIL box_select: got %0d expected 3", pattern_id); end
    while (n_fs < 610) begin
      frame(1'b0, got);
      if (n_fs inside {100, 300, 447, 448, 449, 607, 608, 609, 610}) begin
        bx = tri_pos(n_fs, HRES - BOX); by = tri_pos(n_fs, VRES - BOX);
        px = '{bx, bx + 32, bx - 1, bx + 31};
        py = '{by, by, by, by + 31};
        for (int j = 0; j < 4; j++) begin
          probe(px[j], py[j], 1'b1, got); want = ref_colour(3, px[j], py[j], 1'b1, n_fs);
          n_tests++; if (got !== want) begin
            n_fail++; $display("FAIL box frame %0d (%0d,%0d): got %h expected %h", n_fs, px[j], py[j], got, want); end
        end
      end
    end
    $display("[TB] test_box done");
  endtask

  task automatic test_back_to_back();
    logic [26:0] want_q[$];
    logic [26:0] want;
    int x, y, bx, by;
    bit en, hs, vs;
    bx = tri_pos(n_fs, HRES - BOX); by = tri_pos(n_fs, VRES - BOX);
    for (int i = 0; i < 302; i++) begin
      @(negedge clk_pix);
      if (i >= 2) begin
        want = want_q.pop_front();
        n_tests++; if ({de_o, hsync_o, vsync_o, red, green, blue} !== want) begin
          n_fail++; $display("FAIL stream %0d: got %h expected %h", i - 2, {de_o, hsync_o, vsync_o, red, green, blue}, want); end
      end
      if (i < 300) begin
        if (i % 2 == 0) begin
          x = $urandom_range(0, 700) - 30; y = $urandom_range(0, 540) - 30;
        end else begin
          x = bx + $urandom_range(0, 40) - 4; y = by + $urandom_range(0, 40) - 4;
        end
        en = ($urandom_range(0, 3) != 0); hs = $urandom_range(0, 1); vs = $urandom_range(0, 1);
        sx = 16'(x); sy = 16'(y); video_enable = en; hsync = hs; vsync = vs;
        want_q.push_back({en, hs, vs, ref_colour(exp_pat, x, y, en, n_fs)});
      end else begin
        video_enable = 1'b0; hsync = 1'b0; vsync = 1'b0;
      end
    end
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_reset_mid();
    logic [23:0] got;
    int bx, by;
    bx = tri_pos(n_fs, HRES - BOX); by = tri_pos(n_fs, VRES - BOX);
    @(negedge clk_pix);
    sx = 16'(bx); sy = 16'(by); video_enable = 1'b1; hsync = 1'b1; vsync = 1'b1;
    @(posedge clk_pix); @(posedge clk_pix); #2;
    n_tests++; if ({red, green, blue} !== 24'hFFFFFF) begin
      n_fail++; $display("FAIL midreset_before: got %h expected FFFFFF", {red, green, blue}); end
    rst_n = 1'b0; #1;
    n_tests++; if ({red, green, blue, de_o, hsync_o, vsync_o, pattern_id} !== 30'd0) begin
      n_fail++; $display("FAIL midreset_async: got %h expected 0", {red, green, blue, de_o, hsync_o, vsync_o, pattern_id}); end
    @(negedge clk_pix);
    rst_n = 1'b1; n_fs = 0; exp_pat = 0;
    sx = 16'(80); sy = 16'(10); hsync = 1'b0; vsync = 1'b0;
    n_tests++; if (pattern_id !== 3'd0) begin n_fail++; $display("FAIL midreset_pattern: got %0d expected 0", pattern_id); end
    @(negedge clk_pix); video_enable = 1'b0;
    @(negedge clk_pix);
    n_tests++; if ({de_o, red, green, blue} !== {1'b1, 24'hFFFF00}) begin
      n_fail++; $display("FAIL midreset_resume: got %h expected %h", {de_o, red, green, blue}, {1'b1, 24'hFFFF00}); end
    repeat (3) begin pulse_req(); frame(1'b0, got); end
    exp_pat = 3;
    probe(3, 3, 1'b1, got);
    n_tests++; if (got !== 24'hFFFFFF) begin n_fail++; $display("FAIL midreset_box_in: got %h expected FFFFFF", got); end
    probe(2, 3, 1'b1, got);
    n_tests++; if (got !== 24'h0000FF) begin n_fail++; $display("FAIL midreset_box_left: got %h expected 0000FF", got); end
    probe(35, 3, 1'b1, got);
    n_tests++; if (got !== 24'h0000FF) begin n_fail++; $display("FAIL midreset_box_right: got %h expected 0000FF", got); end
    $display("[TB] test_reset_mid done");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_color_bars();
    test_next_req();
    test_gradient();
    test_auto_cycle();
    test_box();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
